fifo_wr_ctrl: RTL and testbench
===============================

Name: fifo_wr_ctrl

Overview:
Write-side pointer and flag controller for the asynchronous FIFO, second generation. It keeps the write pointer in binary and Gray, and takes the read pointer already synchronised into the write domain. It generates a look-ahead registered full flag, a programmable almost-full flag, a free-running fill level, a memory write strobe and a sticky overflow error. It sits between the write-domain client, the dual-port FIFO memory and the read-to-write pointer synchroniser.

Parameters:
ADDRSIZE, 4, memory address width; DEPTH = 2^ADDRSIZE entries; legal range ADDRSIZE >= 2.

Ports:
CLK  input  1  write-domain clock.
RST  input  1  asynchronous reset, active-high.
wINC  input  1  client write request, one entry per cycle while high.
wq2_rptr  input  ADDRSIZE+1  read pointer (Gray), already synchronised into CLK.
wAFULL_LVL  input  ADDRSIZE+1  almost-full threshold in entries, quasi-static.
wOVF_CLR  input  1  clears the sticky overflow flag.
wEN  output  1  memory write enable.
wADDR  output  ADDRSIZE  memory write address.
wPTR  output  ADDRSIZE+1  write pointer (Gray) sent to the read-domain synchroniser.
wFULL  output  1  FIFO full, registered.
wAFULL  output  1  fill level >= wAFULL_LVL, registered.
wLEVEL  output  ADDRSIZE+1  entries occupied as seen from the write side, registered.
wOVF  output  1  sticky overflow error.

Behaviour:
- Reset: RST high clears all registers immediately, without waiting for CLK.
  - wbin=0, wPTR=0, wFULL=0, wLEVEL=0, wOVF=0.
  - wAFULL=0. This holds during reset regardless of wAFULL_LVL.
  - Combinational outputs: wEN=0 (because wINC is gated by wFULL, and wINC is expected low in reset), wADDR=0.
- Reset mid-operation: all state is lost and pointers return to 0. The read side must be reset in the same window. The block does not resynchronise pointers.
- Accepted write: wEN = wINC & ~wFULL, combinational. wADDR = wbin[ADDRSIZE-1:0], combinational from the register.
- Next-state, every cycle:
  - wbin_n = wbin + wEN. Arithmetic is modulo 2^(ADDRSIZE+1) and wraps naturally from 2*DEPTH-1 to 0.
  - wgray_n = (wbin_n >> 1) ^ wbin_n.
  - rbin = Gray-to-binary of wq2_rptr, using a prefix-XOR from the MSB down.
  - level_n = (wbin_n - rbin) mod 2^(ADDRSIZE+1). The range is 0..DEPTH.
- Registered on CLK rising edge:
  - wbin <= wbin_n
  - wPTR <= wgray_n
  - wFULL <= (wgray_n == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]})
  - wLEVEL <= level_n
  - wAFULL <= (level_n >= wAFULL_LVL)
- Latency:
  - wPTR, wFULL, wLEVEL and wAFULL all reflect a write in the same edge that commits it. There is no bubble between wPTR and wFULL, which is the improvement over gen 1.
  - A change on wq2_rptr affects wFULL, wLEVEL and wAFULL one edge later.
- Pessimism: wLEVEL and the flags use the stale synchronised read pointer. They may over-report occupancy, but never under-report it. wFULL deasserts only after the synchronised read pointer advances.
- Full boundary: with wFULL=1, wINC is ignored. The pointers hold, and no memory write occurs.
- Overflow:
  - wOVF sets on any edge where wINC=1 and wFULL=1.
  - wOVF clears on an edge where wOVF_CLR=1.
  - Set has priority if both occur in the same cycle.
- Threshold edge cases:
  - wAFULL_LVL=0: wAFULL=1 from the first edge after reset.
  - wAFULL_LVL > DEPTH: wAFULL is never asserted.
- Simultaneous write and read-pointer advance: both are folded into level_n in the same edge, so the net level change is (+1 - read advance).
- No state machine. The block is a datapath made of counter, Gray conversion, compare and sticky flag.

Test Plan:
- Reset: assert RST asynchronously mid-cycle -> all outputs 0 immediately. Release, then idle 3 cycles -> outputs remain 0.
- Fill (ADDRSIZE=4, wq2_rptr=0, wAFULL_LVL=12):
  - 12th write -> wAFULL=1 on that edge.
  - 16th write -> wFULL=1, wPTR=5'b11000, wLEVEL=16, wADDR=0.
- Overflow:
  - While full, wINC=1 for 2 cycles -> wEN=0, wPTR unchanged, wOVF=1.
  - Assert wOVF_CLR together with a further overflowing wINC -> wOVF stays 1.
  - Assert wOVF_CLR alone -> wOVF=0 next edge.
- Drain release: from full, set wq2_rptr=5'b00001 -> next edge wFULL=0, wLEVEL=15, wAFULL stays 1.
  - Then set wq2_rptr=Gray(5)=5'b00111 -> next edge wLEVEL=11, wAFULL=0.
- Wrap: stream writes with wq2_rptr tracking Gray(wbin-3) -> after 40 writes:
  - wbin wraps 31->0 cleanly.
  - wPTR sequence is single-bit-change every step.
  - wLEVEL stays 3, and wFULL never asserts.
- Simultaneous events: at level 15, wINC=1 and wq2_rptr advances by 1 in the same cycle -> next edge wLEVEL=15 and wFULL=0.

Source files
------------

// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bundle of the async FIFO: client request, synchronised read pointer,
// memory write port and status flags.
interface fifo_wr_ctrl_if #(
  parameter int ADDRSIZE = 4
);
  logic                wINC;
  logic [ADDRSIZE:0]   wq2_rptr;
  logic [ADDRSIZE:0]   wAFULL_LVL;
  logic                wOVF_CLR;
  logic                wEN;
  logic [ADDRSIZE-1:0] wADDR;
  logic [ADDRSIZE:0]   wPTR;
  logic                wFULL;
  logic                wAFULL;
  logic [ADDRSIZE:0]   wLEVEL;
  logic                wOVF;

  // Drives requests, the synchronised read pointer and configuration.
  modport master (
    output wINC, wq2_rptr, wAFULL_LVL, wOVF_CLR,
    input  wEN, wADDR, wPTR, wFULL, wAFULL, wLEVEL, wOVF
  );

  // The write controller itself.
  modport slave (
    input  wINC, wq2_rptr, wAFULL_LVL, wOVF_CLR,
    output wEN, wADDR, wPTR, wFULL, wAFULL, wLEVEL, wOVF
  );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write-side controller: binary/Gray write pointer, look-ahead full,
// almost-full, fill level and sticky overflow, all updated on the committing edge.
module fifo_wr_ctrl #(
  parameter int ADDRSIZE = 4
) (
  input logic           CLK,
  input logic           RST,
  fifo_wr_ctrl_if.slave bus
);

  localparam int PW = ADDRSIZE + 1;

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_n;
  logic [PW-1:0] wgray_n;
  logic [PW-1:0] rbin;
  logic [PW-1:0] level_n;
  logic [PW-1:0] full_ptr;
  logic          full_n;
  logic          afull_n;
  logic          ovf_set;

  assign bus.wEN   = bus.wINC & ~bus.wFULL;
  assign bus.wADDR = wbin[ADDRSIZE-1:0];

  assign wbin_n  = wbin + {{ADDRSIZE{1'b0}}, bus.wEN};
  assign wgray_n = (wbin_n >> 1) ^ wbin_n;

  // NOTE: every variable assigned in always_comb gets a value before any
  // conditional or loop, so no path can leave it holding its old value (latch).
  always_comb begin
    rbin         = '0;
    rbin[PW-1]   = bus.wq2_rptr[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ bus.wq2_rptr[i];
    end
  end

  assign level_n  = wbin_n - rbin;
  assign afull_n  = (level_n >= bus.wAFULL_LVL);

  // Full when the write pointer is exactly one lap ahead of the read pointer:
  // in Gray this means the two MSBs are inverted and the rest match.
  assign full_ptr = {~bus.wq2_rptr[ADDRSIZE:ADDRSIZE-1], bus.wq2_rptr[ADDRSIZE-2:0]};
  assign full_n   = (wgray_n == full_ptr);

  assign ovf_set  = bus.wINC & bus.wFULL;

  // NOTE: state registers use non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order; the asynchronous reset
  // clears them immediately, without waiting for a clock edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wbin       <= '0;
      bus.wPTR   <= '0;
      bus.wFULL  <= 1'b0;
      bus.wAFULL <= 1'b0;
      bus.wLEVEL <= '0;
      bus.wOVF   <= 1'b0;
    end else begin
      wbin       <= wbin_n;
      bus.wPTR   <= wgray_n;
      bus.wFULL  <= full_n;
      bus.wAFULL <= afull_n;
      bus.wLEVEL <= level_n;
      if (ovf_set) begin
        bus.wOVF <= 1'b1;
      end else if (bus.wOVF_CLR) begin
        bus.wOVF <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl: directed plan scenarios followed by
// randomized traffic, checked against a write/read-count occupancy model.
module tb_fifo_wr_ctrl;

  localparam int A     = 4;
  localparam int PW    = A + 1;
  localparam int DEPTH = 1 << A;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  fifo_wr_ctrl_if #(.ADDRSIZE(A)) bus ();

  fifo_wr_ctrl #(.ADDRSIZE(A)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: total accepted writes and total reads seen by the write side.
  int wr_cnt;
  int rd_cnt;
  int lvl;
  int e_level;
  bit e_full;
  bit e_afull;
  bit e_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] gray(input int n);
    logic [PW-1:0] b;
    b = n[PW-1:0];
    return b ^ (b >> 1);
  endfunction

  // Called just after a rising edge: drive inputs, check the combinational
  // outputs, then advance the model across the next edge and check registers.
  task automatic cycle(input bit inc, input bit clr, input int rd_new);
    bit acc;
    bus.wINC       = inc;
    bus.wOVF_CLR   = clr;
    bus.wq2_rptr   = gray(rd_new);
    bus.wAFULL_LVL = lvl[PW-1:0];
    #1;
    acc = inc && !e_full;
    check("wEN", bus.wEN, acc);
    check("wADDR", bus.wADDR, wr_cnt % DEPTH);
    @(posedge CLK);
    #1;
    if (inc && e_full) e_ovf = 1'b1;
    else if (clr)      e_ovf = 1'b0;
    wr_cnt  += int'(acc);
    rd_cnt   = rd_new;
    e_level  = wr_cnt - rd_cnt;
    e_full   = (e_level == DEPTH);
    e_afull  = (e_level >= lvl);
    check("wPTR", bus.wPTR, gray(wr_cnt));
    check("wLEVEL", bus.wLEVEL, e_level);
    check("wFULL", bus.wFULL, e_full);
    check("wAFULL", bus.wAFULL, e_afull);
    check("wOVF", bus.wOVF, e_ovf);
  endtask

  // Asserts reset between clock edges and checks that outputs clear at once.
  task automatic do_reset();
    #2;
    RST          = 1'b1;
    bus.wINC     = 1'b0;
    bus.wOVF_CLR = 1'b0;
    bus.wq2_rptr = '0;
    #1;
    wr_cnt = 0; rd_cnt = 0; e_level = 0;
    e_full = 1'b0; e_afull = 1'b0; e_ovf = 1'b0;
    check("rst_wPTR", bus.wPTR, 0);
    check("rst_wFULL", bus.wFULL, 0);
    check("rst_wAFULL", bus.wAFULL, 0);
    check("rst_wLEVEL", bus.wLEVEL, 0);
    check("rst_wOVF", bus.wOVF, 0);
    check("rst_wEN", bus.wEN, 0);
    check("rst_wADDR", bus.wADDR, 0);
    @(negedge CLK);
    RST = 1'b0;
    cycle(1'b0, 1'b0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [PW-1:0] prev_ptr;
    lvl            = 12;
    bus.wINC       = 1'b0;
    bus.wOVF_CLR   = 1'b0;
    bus.wq2_rptr   = '0;
    bus.wAFULL_LVL = PW'(12);

    // Reset from power-up, then mid-operation, then idle.
    do_reset();
    repeat (5) cycle(1'b1, 1'b0, 0);
    do_reset();
    repeat (3) cycle(1'b0, 1'b0, 0);

    // Fill to full with the read pointer parked at 0.
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, 1'b0, 0);
      if (i == 11) check("afull_before_12", bus.wAFULL, 0);
      if (i == 12) check("afull_at_12", bus.wAFULL, 1);
    end
    check("full_at_16", bus.wFULL, 1);
    check("ptr_at_16", bus.wPTR, 5'b11000);
    check("level_at_16", bus.wLEVEL, 16);
    check("addr_at_16", bus.wADDR, 0);

    // Overflow while full, clear priority, then clear alone.
    repeat (2) cycle(1'b1, 1'b0, 0);
    check("ovf_ptr_hold", bus.wPTR, 5'b11000);
    check("ovf_set", bus.wOVF, 1);
    cycle(1'b1, 1'b1, 0);
    check("ovf_set_wins", bus.wOVF, 1);
    cycle(1'b0, 1'b1, 0);
    check("ovf_cleared", bus.wOVF, 0);

    // Drain release via the synchronised read pointer.
    cycle(1'b0, 1'b0, 1);
    check("drain1_full", bus.wFULL, 0);
    check("drain1_level", bus.wLEVEL, 15);
    check("drain1_afull", bus.wAFULL, 1);
    cycle(1'b0, 1'b0, 5);
    check("drain5_level", bus.wLEVEL, 11);
    check("drain5_afull", bus.wAFULL, 0);

    // Streaming wrap with the reader trailing three entries behind.
    do_reset();
    repeat (3) cycle(1'b1, 1'b0, 0);
    for (int i = 0; i < 40; i++) begin
      prev_ptr = bus.wPTR;
      cycle(1'b1, 1'b0, wr_cnt + 1 - 3);
      check("wrap_gray_step", $countones(prev_ptr ^ bus.wPTR), 1);
      check("wrap_level", bus.wLEVEL, 3);
    end
    check("wrap_addr", bus.wADDR, 43 % DEPTH);

    // Simultaneous write and read advance at level 15.
    repeat (12) cycle(1'b1, 1'b0, rd_cnt);
    check("pre_simul_level", bus.wLEVEL, 15);
    cycle(1'b1, 1'b0, rd_cnt + 1);
    check("simul_level", bus.wLEVEL, 15);
    check("simul_full", bus.wFULL, 0);

    // Zero threshold asserts almost-full on the first edge after reset.
    lvl = 0;
    bus.wAFULL_LVL = '0;
    do_reset();
    check("lvl0_afull", bus.wAFULL, 1);

    // Randomized traffic, thresholds including values above DEPTH.
    for (int i = 0; i < 600; i++) begin
      bit inc;
      bit clr;
      int rd_new;
      if (i % 60 == 0) lvl = $urandom_range(DEPTH + 1, 0);
      inc    = ($urandom_range(99, 0) < 70);
      clr    = ($urandom_range(99, 0) < 8);
      rd_new = rd_cnt;
      if (rd_cnt < wr_cnt && $urandom_range(99, 0) < 40) rd_new = rd_cnt + 1;
      cycle(inc, clr, rd_new);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
